// File: rtl/fibonacci_index.sv
`default_nettype none
// ============================================================================
// fibonacci_index : iterative inverse Fibonacci search, one sequence step/clk
// Rev 1.0
// ============================================================================
module fibonacci_index #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value_in,
  input  logic             begin_inv,
  output logic [IDX_W-1:0] idx_out,
  output logic             exact,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [WIDTH:0] C_B_ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] C_B_SAT = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   b_q, b_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             exact_q, exact_d;
  logic [WIDTH:0]   w_sum;

  // a and b are both <= target whenever a step is taken, so the sum fits WIDTH+1 bits
  assign w_sum = {1'b0, a_q} + b_q;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    idx_d    = idx_q;
    exact_d  = exact_q;
    case (state_q)
      S_IDLE: begin
        if (begin_inv) begin
          target_d = value_in;
          a_d      = '0;
          b_d      = C_B_ONE;
          n_d      = '0;
          state_d  = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (a_q == target_q) begin
          idx_d   = n_q;
          exact_d = 1'b1;
          state_d = S_DONE;
        end else if (b_q[WIDTH] || (b_q[WIDTH-1:0] > target_q)) begin
          idx_d   = n_q;
          exact_d = 1'b0;
          state_d = S_DONE;
        end else begin
          a_d = b_q[WIDTH-1:0];
          // Saturation guarantees the overflow test fires on the next compare
          b_d = w_sum[WIDTH] ? C_B_SAT : w_sum;
          n_d = n_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      a_q      <= '0;
      b_q      <= C_B_ONE;
      n_q      <= '0;
      idx_q    <= '0;
      exact_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      exact_q  <= exact_d;
    end
  end

  assign idx_out = idx_q;
  assign exact   = exact_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fibonacci_index.sv
`default_nettype none
// ============================================================================
// tb_fibonacci_index : scoreboard bench for the inverse Fibonacci search
// Rev 1.0
// ============================================================================
module tb_fibonacci_index;
  localparam int WIDTH = 16;
  localparam int IDX_W = 5;
  localparam int TMO   = 60;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             begin_inv = 1'b0;
  logic [WIDTH-1:0] value_in = '0;
  logic [IDX_W-1:0] idx_out;
  logic             exact, busy, done;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             exact;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fibonacci_index #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .begin_inv(begin_inv),
    .idx_out(idx_out), .exact(exact), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] fib(input int n);
    longint a = 0;
    longint b = 1;
    longint t;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return WIDTH'(a);
  endfunction

  // Drive one begin pulse from an IDLE cycle and record the expected result
  task automatic start(input logic [WIDTH-1:0] v, input logic [IDX_W-1:0] ei, input logic ee);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < TMO) begin
      @(negedge clk);
      guard++;
    end
    value_in  = v;
    begin_inv = 1'b1;
    e.idx   = ei;
    e.exact = ee;
    e.lat   = int'(ei) + 2;
    sb.push_back(e);
  endtask

  // Count edges from the accepting edge (edge 1) until done is seen
  task automatic wait_done(input bit drop, input int inj_at, input logic [WIDTH-1:0] inj_v,
                           output int cyc, output int busy_low, output bit to);
    cyc = 0;
    busy_low = 0;
    to = 1'b1;
    while (cyc < TMO) begin
      @(posedge clk);
      #1;
      cyc++;
      if (drop) begin_inv = (cyc == inj_at);
      if (cyc == inj_at) value_in = inj_v;
      if (done) begin
        to = 1'b0;
        break;
      end
      if (!busy) busy_low++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (idx_out !== '0) begin n_err++; $display("FAIL reset_idx: got %0d expected 0", idx_out); end
    n_cmp++; if (exact !== 1'b0) begin n_err++; $display("FAIL reset_exact: got %b expected 0", exact); end
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exact();
    logic [WIDTH-1:0] vals [4] = '{16'd0, 16'd1, 16'd13, 16'd46368};
    logic [IDX_W-1:0] idxs [4] = '{5'd0, 5'd1, 5'd7, 5'd24};
    exp_t e;
    int cyc, bl;
    bit to;
    for (int i = 0; i < 4; i++) begin
      start(vals[i], idxs[i], 1'b1);
      wait_done(1'b1, 0, '0, cyc, bl, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_err++; $display("FAIL exact_timeout v=%0d: no done in %0d cycles", vals[i], TMO); end
      n_cmp++; if (idx_out !== e.idx) begin n_err++; $display("FAIL exact_idx v=%0d: got %0d expected %0d", vals[i], idx_out, e.idx); end
      n_cmp++; if (exact !== e.exact) begin n_err++; $display("FAIL exact_flag v=%0d: got %b expected %b", vals[i], exact, e.exact); end
      n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL exact_latency v=%0d: got %0d expected %0d", vals[i], cyc, e.lat); end
      n_cmp++; if (bl !== 0) begin n_err++; $display("FAIL exact_busy v=%0d: busy low %0d cycles expected 0", vals[i], bl); end
      @(posedge clk);
      #1;
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL exact_pulse v=%0d: done=%b busy=%b expected 0 0", vals[i], done, busy); end
      n_cmp++; if (idx_out !== e.idx) begin n_err++; $display("FAIL exact_hold v=%0d: got %0d expected %0d", vals[i], idx_out, e.idx); end
    end
  endtask

  task automatic test_inexact();
    logic [WIDTH-1:0] vals [2] = '{16'd100, 16'd65535};
    logic [IDX_W-1:0] idxs [2] = '{5'd11, 5'd24};
    exp_t e;
    int cyc, bl;
    bit to;
    for (int i = 0; i < 2; i++) begin
      start(vals[i], idxs[i], 1'b0);
      wait_done(1'b1, 0, '0, cyc, bl, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_err++; $display("FAIL inexact_timeout v=%0d: no done in %0d cycles", vals[i], TMO); end
      n_cmp++; if (idx_out !== e.idx) begin n_err++; $display("FAIL inexact_idx v=%0d: got %0d expected %0d", vals[i], idx_out, e.idx); end
      n_cmp++; if (exact !== e.exact) begin n_err++; $display("FAIL inexact_flag v=%0d: got %b expected %b", vals[i], exact, e.exact); end
      n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL inexact_latency v=%0d: got %0d expected %0d", vals[i], cyc, e.lat); end
    end
  endtask

  task automatic test_ignore_begin();
    exp_t e;
    int cyc, bl;
    bit to;
    start(16'd1000, 5'd16, 1'b0);
    wait_done(1'b1, 3, 16'd21, cyc, bl, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL ignore_timeout: no done in %0d cycles", TMO); end
    n_cmp++; if (idx_out !== e.idx) begin n_err++; $display("FAIL ignore_idx: got %0d expected %0d", idx_out, e.idx); end
    n_cmp++; if (exact !== e.exact) begin n_err++; $display("FAIL ignore_flag: got %b expected %b", exact, e.exact); end
    n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL ignore_latency: got %0d expected %0d", cyc, e.lat); end
    n_cmp++; if (bl !== 0) begin n_err++; $display("FAIL ignore_busy: busy low %0d cycles expected 0", bl); end
    repeat (3) begin
      @(posedge clk);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_restart: busy=%b expected 0", busy); end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int cyc, bl;
    bit to;
    int seen;
    seen = 0;
    @(negedge clk);
    value_in  = 16'd1000;
    begin_inv = 1'b1;
    @(negedge clk);
    begin_inv = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen++;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (idx_out !== '0 || exact !== 1'b0) begin n_err++; $display("FAIL abort_outputs: idx=%0d exact=%b expected 0 0", idx_out, exact); end
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_idle: %0d done/busy cycles expected 0", seen); end
    start(16'd21, 5'd8, 1'b1);
    wait_done(1'b1, 0, '0, cyc, bl, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL abort_timeout: no done in %0d cycles", TMO); end
    n_cmp++; if (idx_out !== e.idx || exact !== e.exact) begin n_err++; $display("FAIL abort_next: got %0d/%b expected %0d/%b", idx_out, exact, e.idx, e.exact); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc, bl;
    bit to;
    start(16'd13, 5'd7, 1'b1);
    wait_done(1'b0, 0, '0, cyc, bl, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL b2b_first_timeout: no done in %0d cycles", TMO); end
    n_cmp++; if (idx_out !== e.idx || exact !== e.exact || cyc !== e.lat) begin n_err++; $display("FAIL b2b_first: got %0d/%b/%0d expected %0d/%b/%0d", idx_out, exact, cyc, e.idx, e.exact, e.lat); end
    value_in = 16'd100;
    e.idx = 5'd11; e.exact = 1'b0; e.lat = 14;
    sb.push_back(e);
    wait_done(1'b0, 0, '0, cyc, bl, to);
    begin_inv = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL b2b_second_timeout: no done in %0d cycles", TMO); end
    n_cmp++; if (idx_out !== e.idx || exact !== e.exact) begin n_err++; $display("FAIL b2b_second: got %0d/%b expected %0d/%b", idx_out, exact, e.idx, e.exact); end
    n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, e.lat); end
    n_cmp++; if (bl !== 1) begin n_err++; $display("FAIL b2b_idle: busy low %0d cycles expected 1", bl); end
  endtask

  task automatic test_round_trip();
    exp_t e;
    int cyc, bl;
    bit to;
    logic [WIDTH-1:0] v;
    for (int n = 0; n <= 24; n++) begin
      v = fib(n);
      start(v, (n == 2) ? IDX_W'(1) : IDX_W'(n), 1'b1);
      wait_done(1'b1, 0, '0, cyc, bl, to);
      e = sb.pop_front();
      n_cmp++; if (to || idx_out !== e.idx || exact !== e.exact || cyc !== e.lat) begin
        n_err++; $display("FAIL rt_exact n=%0d v=%0d: got %0d/%b/%0d expected %0d/%b/%0d", n, v, idx_out, exact, cyc, e.idx, e.exact, e.lat);
      end
    end
    for (int n = 4; n <= 24; n++) begin
      v = fib(n) + WIDTH'(1);
      start(v, IDX_W'(n), 1'b0);
      wait_done(1'b1, 0, '0, cyc, bl, to);
      e = sb.pop_front();
      n_cmp++; if (to || idx_out !== e.idx || exact !== e.exact || cyc !== e.lat) begin
        n_err++; $display("FAIL rt_plus1 n=%0d v=%0d: got %0d/%b/%0d expected %0d/%b/%0d", n, v, idx_out, exact, cyc, e.idx, e.exact, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_inexact();
    test_ignore_begin();
    test_abort();
    test_back_to_back();
    test_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
